// File: rtl/biquad_cascade.sv
// biquad_cascade
//   Cascade of NSECT Direct-Form-I second-order IIR sections. All sections
//   share one multiply-accumulate datapath, so each sample takes
//   6*NSECT cycles of compute: five MAC cycles and one update cycle per
//   section.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   x, in_valid, in_ready input sample stream (Q1.(DATAWIDTH-1))
//   y, out_valid, out_ready output sample stream; y is held until taken
//   clear                 zero all section history and sat_flag (idle only)
//   coef_we/addr/wdata    coefficient write port, addr = 5*section + index
//                         with index order b0,b1,b2,a1,a2 (Q2.(COEFWIDTH-2))
//   coef_err              one-cycle pulse after a write dropped while busy
//   sat_flag              sticky, set when any section output saturates
module biquad_cascade #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16,
  parameter int NSECT     = 2,
  parameter int ACCUM     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATAWIDTH-1:0]       x,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATAWIDTH-1:0]       y,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clear,
  input  logic                       coef_we,
  input  logic [$clog2(5*NSECT)-1:0] coef_addr,
  input  logic [COEFWIDTH-1:0]       coef_wdata,
  output logic                       coef_err,
  output logic                       sat_flag
);

  localparam int NCOEF = 5 * NSECT;
  localparam int CAW   = $clog2(NCOEF);
  localparam int PW    = DATAWIDTH + COEFWIDTH;
  localparam int AW    = PW + ACCUM;
  localparam int SW    = (NSECT > 1) ? $clog2(NSECT) : 1;
  localparam int SH    = COEFWIDTH - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [COEFWIDTH-1:0] UNITY = {2'b01, {(COEFWIDTH-2){1'b0}}};
  localparam logic signed [AW-1:0] RND  = {{(AW-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [AW-1:0] SMAX = {{(AW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

  logic [1:0]                  state_q, state_d;
  logic [SW-1:0]               sect_q, sect_d;
  logic [2:0]                  term_q, term_d;
  logic signed [AW-1:0]        acc_q, acc_d;
  logic signed [DATAWIDTH-1:0] xin_q, xin_d;
  logic signed [DATAWIDTH-1:0] y_q, y_d;
  logic                        sat_q, sat_d;
  logic                        err_q, err_d;

  logic signed [DATAWIDTH-1:0] x1_q [NSECT];
  logic signed [DATAWIDTH-1:0] x2_q [NSECT];
  logic signed [DATAWIDTH-1:0] y1_q [NSECT];
  logic signed [DATAWIDTH-1:0] y2_q [NSECT];
  logic signed [COEFWIDTH-1:0] coef_q [NCOEF];

  logic [CAW-1:0]              cidx;
  logic signed [DATAWIDTH-1:0] opnd;
  logic signed [COEFWIDTH-1:0] cf;
  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        rnd;
  logic signed [AW-1:0]        shf;
  logic signed [DATAWIDTH-1:0] yk;
  logic                        sat_now;
  logic                        addr_ok;
  logic                        hist_clr;
  logic                        hist_upd;
  logic                        coef_wr;

  // Shared datapath: operand/coefficient select, product, round, saturate.
  always_comb begin
    cidx = CAW'(sect_q) * CAW'(5) + CAW'(term_q);
    case (term_q)
      3'd0:    opnd = xin_q;
      3'd1:    opnd = x1_q[sect_q];
      3'd2:    opnd = x2_q[sect_q];
      3'd3:    opnd = y1_q[sect_q];
      3'd4:    opnd = y2_q[sect_q];
      default: opnd = '0;
    endcase
    cf   = coef_q[cidx];
    prod = opnd * cf;
    rnd  = acc_q + RND;
    shf  = rnd >>> SH;
    sat_now = 1'b1;
    if (shf > SMAX) begin
      yk = {1'b0, {(DATAWIDTH-1){1'b1}}};
    end else if (shf < SMIN) begin
      yk = {1'b1, {(DATAWIDTH-1){1'b0}}};
    end else begin
      yk      = shf[DATAWIDTH-1:0];
      sat_now = 1'b0;
    end
    addr_ok = int'(coef_addr) < NCOEF;
  end

  // Sequencer.
  always_comb begin
    state_d  = state_q;
    sect_d   = sect_q;
    term_d   = term_q;
    acc_d    = acc_q;
    xin_d    = xin_q;
    y_d      = y_q;
    sat_d    = sat_q;
    err_d    = coef_we && addr_ok && (state_q != S_IDLE);
    hist_clr = 1'b0;
    hist_upd = 1'b0;
    coef_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        coef_wr = coef_we && addr_ok;
        if (clear) begin
          hist_clr = 1'b1;
          sat_d    = 1'b0;
        end else if (in_valid) begin
          xin_d   = x;
          acc_d   = '0;
          sect_d  = '0;
          term_d  = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + $signed({{ACCUM{prod[PW-1]}}, prod});
        if (term_q == 3'd4) begin
          state_d = S_UPD;
        end else begin
          term_d = term_q + 3'd1;
        end
      end
      S_UPD: begin
        hist_upd = 1'b1;
        if (sat_now) begin
          sat_d = 1'b1;
        end
        // The section output becomes the next section's input sample.
        if (int'(sect_q) < NSECT - 1) begin
          sect_d  = sect_q + SW'(1);
          term_d  = '0;
          acc_d   = '0;
          xin_d   = yk;
          state_d = S_MAC;
        end else begin
          y_d     = yk;
          state_d = S_OUT;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sect_q  <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      xin_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sect_q  <= sect_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      xin_q   <= xin_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  // History and coefficient storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSECT; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NCOEF; i++) begin
        coef_q[i] <= (i % 5 == 0) ? UNITY : '0;
      end
    end else begin
      if (hist_clr) begin
        for (int unsigned i = 0; i < NSECT; i++) begin
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          y1_q[i] <= '0;
          y2_q[i] <= '0;
        end
      end else if (hist_upd) begin
        x2_q[sect_q] <= x1_q[sect_q];
        x1_q[sect_q] <= xin_q;
        y2_q[sect_q] <= y1_q[sect_q];
        y1_q[sect_q] <= yk;
      end
      if (coef_wr) begin
        coef_q[coef_addr] <= coef_wdata;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !clear;
  assign out_valid = (state_q == S_OUT);
  assign y         = y_q;
  assign coef_err  = err_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_biquad_cascade.sv
module tb_biquad_cascade;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic        clear;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        coef_err;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

  biquad_cascade #(.DATAWIDTH(16), .COEFWIDTH(16), .NSECT(2), .ACCUM(4)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready), .clear(clear),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: the section equation evaluated with plain integers.
  int mc [10];
  int mx1 [2];
  int mx2 [2];
  int my1 [2];
  int my2 [2];
  bit msat;

  function automatic void model_clear();
    for (int s = 0; s < 2; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
    msat = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) mc[i] = (i % 5 == 0) ? 16384 : 0;
    model_clear();
  endfunction

  function automatic logic [15:0] model_sample(input logic [15:0] xs);
    int xin = int'($signed(xs));
    longint w;
    longint r;
    for (int s = 0; s < 2; s++) begin
      w = longint'(mc[5*s]) * xin + longint'(mc[5*s+1]) * mx1[s] +
          longint'(mc[5*s+2]) * mx2[s] + longint'(mc[5*s+3]) * my1[s] +
          longint'(mc[5*s+4]) * my2[s];
      r = (w + 64'sd8192) >>> 14;
      if (r > 32767) begin
        r = 32767; msat = 1'b1;
      end else if (r < -32768) begin
        r = -32768; msat = 1'b1;
      end
      mx2[s] = mx1[s]; mx1[s] = xin;
      my2[s] = my1[s]; my1[s] = int'(r);
      xin = int'(r);
    end
    return 16'(xin);
  endfunction

  // Stimulus drivers (no checking of DUT results inside).
  task automatic do_write(input int addr, input int val);
    logic [15:0] v = 16'(val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (addr < 10) mc[addr] = int'($signed(v));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic drive_accept(input logic [15:0] xs);
    int n = 0;
    @(negedge clk);
    x = xs; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_sample(input logic [15:0] xs, output logic [15:0] yo, output int lat);
    drive_accept(xs);
    wait_out(1, lat);
    yo = y;
    @(posedge clk); #1;
  endtask

  task automatic set_passthrough();
    for (int i = 0; i < 10; i++) do_write(i, (i % 5 == 0) ? 16'h4000 : 0);
    do_clear();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (y !== 16'h0000) begin errors++; $display("FAIL rst_y: got %h want 0000", y); end
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL rst_coef_err: got %b want 0", coef_err); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_sat_flag: got %b want 0", sat_flag); end
  endtask

  task automatic test_passthrough();
    logic [15:0] vals [2];
    logic [15:0] e, yo;
    int lat;
    vals[0] = 16'h1234; vals[1] = 16'h8000;
    for (int i = 0; i < 2; i++) begin
      e = model_sample(vals[i]);
      run_sample(vals[i], yo, lat);
      checks++; if (yo !== e || e !== vals[i]) begin errors++; $display("FAIL pass_y: got %h want %h", yo, vals[i]); end
      checks++; if (lat !== 13) begin errors++; $display("FAIL pass_latency: got %0d want 13", lat); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL pass_return_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL pass_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_impulse();
    logic [15:0] seq [6];
    logic [15:0] e, yo;
    int lat;
    seq[0] = 16'h4000;
    for (int i = 1; i < 6; i++) seq[i] = 16'h0000;
    do_write(0, 16'h2000);
    do_write(3, 16'h2000);
    do_clear();
    for (int i = 0; i < 6; i++) begin
      e = model_sample(seq[i]);
      run_sample(seq[i], yo, lat);
      checks++; if (yo !== e) begin errors++; $display("FAIL impulse_y%0d: got %h want %h", i, yo, e); end
    end
    do_clear();
    e = model_sample(16'h0000);
    run_sample(16'h0000, yo, lat);
    checks++; if (yo !== e) begin errors++; $display("FAIL impulse_after_clear: got %h want %h", yo, e); end
  endtask

  task automatic test_saturation();
    logic [15:0] e, yo;
    int lat;
    for (int i = 0; i < 10; i++) do_write(i, (i % 5 == 0) ? 16'h7FFF : 0);
    do_clear();
    e = model_sample(16'h7000);
    run_sample(16'h7000, yo, lat);
    checks++; if (yo !== e) begin errors++; $display("FAIL sat_pos_y: got %h want %h", yo, e); end
    checks++; if (sat_flag !== msat) begin errors++; $display("FAIL sat_flag_set: got %b want %b", sat_flag, msat); end
    e = model_sample(16'h9000);
    run_sample(16'h9000, yo, lat);
    checks++; if (yo !== e) begin errors++; $display("FAIL sat_neg_y: got %h want %h", yo, e); end
    @(negedge clk);
    clear = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, y0;
    int lat;
    set_passthrough();
    @(negedge clk);
    out_ready = 1'b0;
    e = model_sample(16'h0ABC);
    drive_accept(16'h0ABC);
    wait_out(1, lat);
    y0 = y;
    checks++; if (y0 !== e || lat !== 13) begin errors++; $display("FAIL bp_first: y=%h lat=%0d want %h/13", y0, lat, e); end
    x = 16'h0DEF; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (y !== y0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: y=%h out_valid=%b in_ready=%b want %h/1/0", i, y, out_valid, in_ready, y0);
      end
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_take: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = model_sample(16'h0DEF);
    wait_out(1, lat);
    checks++; if (y !== e || lat !== 13) begin errors++; $display("FAIL bp_second: y=%h lat=%0d want %h/13", y, lat, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_writes();
    logic [15:0] e, yo;
    int lat;
    do_write(1, 16'h2000);
    do_clear();
    e = model_sample(16'h1000);
    run_sample(16'h1000, yo, lat);
    checks++; if (yo !== e) begin errors++; $display("FAIL busy_prime: got %h want %h", yo, e); end
    e = model_sample(16'h0800);
    drive_accept(16'h0800);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'h1000; clear = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0; clear = 1'b0;
    checks++; if (coef_err !== 1'b1) begin errors++; $display("FAIL busy_err_pulse: got %b want 1", coef_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL busy_err_end: got %b want 0", coef_err); end
    wait_out(3, lat);
    checks++; if (y !== e || lat !== 13) begin errors++; $display("FAIL busy_result: y=%h lat=%0d want %h/13", y, lat, e); end
    @(posedge clk); #1;
    do_write(0, 16'h1000);
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL idle_write_err: got %b want 0", coef_err); end
    do_write(12, 16'h7777);
    checks++; if (coef_err !== 1'b0) begin errors++; $display("FAIL oob_write_err: got %b want 0", coef_err); end
    e = model_sample(16'h2000);
    run_sample(16'h2000, yo, lat);
    checks++; if (yo !== e) begin errors++; $display("FAIL idle_write_effect: got %h want %h", yo, e); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e, yo;
    int lat;
    int seen = 0;
    do_write(0, 16'h2000);
    drive_accept(16'h1111);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 16'h0000) begin errors++; $display("FAIL midrst_during: out_valid=%b in_ready=%b y=%h want 0/1/0000", out_valid, in_ready, y); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_out_valid: got %0d valid cycles want 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    e = model_sample(16'h5A5A);
    run_sample(16'h5A5A, yo, lat);
    checks++; if (yo !== e || e !== 16'h5A5A) begin errors++; $display("FAIL midrst_passthrough: got %h want 5a5a", yo); end
  endtask

  task automatic test_random();
    logic [15:0] e, yo, xs;
    int lat;
    for (int i = 0; i < 10; i++) do_write(i, int'($urandom_range(0, 65535)));
    do_clear();
    for (int n = 0; n < 16; n++) begin
      xs = 16'($urandom_range(0, 65535));
      e = model_sample(xs);
      run_sample(xs, yo, lat);
      checks++; if (yo !== e || lat !== 13) begin errors++; $display("FAIL rand_y%0d: x=%h y=%h lat=%0d want %h/13", n, xs, yo, lat, e); end
      checks++; if (sat_flag !== msat) begin errors++; $display("FAIL rand_sat%0d: got %b want %b", n, sat_flag, msat); end
    end
  endtask

  initial begin
    reset = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_busy_writes();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/biquad_cascade.md
Name: biquad_cascade

Overview:
- Parametrised successor to the single-section bi-quad IIR: a cascade of NSECT Direct-Form-I second-order sections computed sequentially on one shared multiply-accumulate datapath.
- Uses true two's-complement arithmetic throughout, with coefficients loaded through a register write port.
- Adds per-section rounding and saturation, a valid/ready handshake on both sides, and a history-clear control.
- Sits between a sample source (ADC/decimator) and downstream DSP in the sensor-node signal chain.

Parameters:
- DATAWIDTH, 16, sample width; signed Q1.(DATAWIDTH-1).
- COEFWIDTH, 16, coefficient width; signed Q2.(COEFWIDTH-2), range [-2,2).
- NSECT, 2, number of cascaded sections, 1..8.
- ACCUM, 4, accumulator guard bits; accumulator width is DATAWIDTH+COEFWIDTH+ACCUM.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  DATAWIDTH  input sample.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept x.
- y  out  DATAWIDTH  filtered output sample.
- out_valid  out  1  y is valid.
- out_ready  in  1  downstream accepts y.
- clear  in  1  zero all section history and sat_flag.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(5*NSECT)  address = 5*section + index; index order b0,b1,b2,a1,a2.
- coef_wdata  in  COEFWIDTH  coefficient value.
- coef_err  out  1  one-cycle pulse when a write is dropped.
- sat_flag  out  1  sticky: some section saturated.

Behaviour:
- Section equation:
  - w = b0*xin + b1*x1 + b2*x2 + a1*y1 + a2*y2. The sign of the feedback terms is carried in a1/a2.
  - xin is x for section 0, else the previous section's output.
  - Section output yk = sat(round(w)).
- Arithmetic:
  - Products are full precision (DATAWIDTH+COEFWIDTH bits), sign-extended into the accumulator.
  - round(w) = (w + 2^(COEFWIDTH-3)) >>> (COEFWIDTH-2), arithmetic shift.
  - sat clamps to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1] and sets sat_flag.
  - The accumulator itself never wraps within ACCUM guard bits.
- State per section: x1, x2, y1, y2, each DATAWIDTH.
- Per-section update: x2<=x1, x1<=xin, y2<=y1, y1<=yk.
- Reset values:
  - in_ready=1, out_valid=0, y=0, coef_err=0, sat_flag=0.
  - All history is 0.
  - Coefficients: b0=2^(COEFWIDTH-2) (unity), all others 0, so every section is a passthrough after reset.
- FSM states: IDLE, MAC, UPD, OUT.
- IDLE:
  - in_ready=1, except in_ready=0 while clear=1.
  - in_valid&in_ready latches x and goes to MAC with section 0, term 0.
  - clear=1 zeros history and sat_flag in that cycle; clear has priority over in_valid.
- MAC:
  - Exactly one product accumulated per cycle, terms b0..a2 in order.
  - After term 4, go to UPD.
- UPD (1 cycle):
  - Round, saturate and update that section's history.
  - If the section index < NSECT-1: next section, accumulator zeroed, back to MAC.
  - Otherwise: register y and go to OUT.
- OUT:
  - out_valid=1; y is held stable until out_ready=1.
  - On out_valid&out_ready, go to IDLE in the next cycle.
- Latency:
  - The accept cycle is cycle 0.
  - out_valid rises in cycle 6*NSECT+1 (13 for NSECT=2).
  - Throughput is at most one sample per 6*NSECT+2 cycles with out_ready tied high.
- in_ready=0 in MAC, UPD and OUT; a new sample is never accepted before the current y is taken.
- clear outside IDLE is ignored and not deferred.
- Coefficient writes:
  - Honoured only in IDLE; the value is used from the next accepted sample.
  - A write in MAC/UPD/OUT is dropped, and coef_err pulses 1 cycle later.
  - coef_addr >= 5*NSECT is ignored with no error.
  - A write and an in_valid accept in the same IDLE cycle: the write takes effect first.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and restores all reset values, including coefficients.
  - The in-flight sample is lost.

Test Plan:
- Post-reset passthrough, D=C=16, NSECT=2: x=0x1234 accepted at cycle 0 -> out_valid in cycle 13 with y=0x1234; x=0x8000 -> y=0x8000; sat_flag stays 0.
- Recursive impulse: sec0 b0=0x2000, a1=0x2000, sec1 unity; feed 0x4000 then zeros -> y = 0x2000, 0x1000, 0x0800, 0x0400, ...; clear then 0 -> y=0x0000.
- Saturation: b0=0x7FFF in both sections, x=0x7000 -> y=0x7FFF and sat_flag=1; x=0x9000 -> y=0x8000; clear -> sat_flag=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> y and out_valid held and in_ready=0; a second x offered meanwhile is accepted only in the cycle after the out_valid&out_ready handshake.
- Busy writes: coef_we to addr 0 during MAC -> coef_err pulses, coefficient unchanged (passthrough result); the same write in IDLE takes effect on the next sample; clear during MAC is ignored (history unchanged).
- Reset mid-sample: assert reset in cycle 5 after accept, with coefficients previously modified -> out_valid stays 0, in_ready=1 after release; the next sample passes through unchanged.
